// File: rtl/risa_pkg.sv
// risa_pkg: shared definitions for the AXI-lite register bank.
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - write-path FSM states (W_IDLE, W_COMMIT, W_RESP)
//   - read-path FSM states (R_IDLE, R_DATA)
package risa_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_wr_merge.sv
// axi_lite_wr_merge: latches the AXI-lite AW and W channels independently and
// reports when both halves of a write are available.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   awaddr/awvalid/awready, wdata/wstrb/wvalid/wready   AXI-lite AW and W
//   accept             write FSM is idle; readies may be offered
//   consume            write FSM is committing; drop both latched halves
//   joined             both halves latched, or completing their handshake now
//   addr, data, strb   latched write request
module axi_lite_wr_merge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  accept,
  input  logic                  consume,
  output logic                  joined,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     data,
  output logic [DATA_W/8-1:0]   strb
);

  logic                aw_have_reg;
  logic                w_have_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [DATA_W/8-1:0] strb_reg;
  logic                aw_hs;
  logic                w_hs;

  // Each channel is offered only until it has been captured once.
  assign awready = accept && !aw_have_reg;
  assign wready  = accept && !w_have_reg;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Counting an in-flight handshake lets AW+W in the same cycle go straight
  // to commit on the next edge.
  assign joined = (aw_have_reg || aw_hs) && (w_have_reg || w_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_have_reg <= 1'b0;
      w_have_reg  <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      strb_reg    <= '0;
    end else if (consume) begin
      aw_have_reg <= 1'b0;
      w_have_reg  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_have_reg <= 1'b1;
        addr_reg    <= awaddr;
      end
      if (w_hs) begin
        w_have_reg <= 1'b1;
        data_reg   <= wdata;
        strb_reg   <= wstrb;
      end
    end
  end

  assign addr = addr_reg;
  assign data = data_reg;
  assign strb = strb_reg;

endmodule

// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank: AXI-lite slave exposing NUM_REGS words of DATA_W bits.
// Registers flagged in RO_MASK are read-only and read back status_i; writes
// to registers flagged in PULSE_MASK raise a one-cycle reg_wr_pulse strobe.
// Optional feature macro: AXI_LITE_REG_DECERR_EN -- when defined, out-of-range
// accesses answer DECERR and read-only writes answer SLVERR; otherwise every
// response is OKAY.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   s_aw*, s_w*, s_b*, s_ar*, s_r*    AXI-lite slave channels
//   reg_q         [NUM_REGS*DATA_W]   current contents of every register word
//   status_i      [NUM_REGS*DATA_W]   read-back source for read-only words
//   reg_wr_pulse  [NUM_REGS]          strobe in the cycle after a committed write
module axi_lite_reg_bank
  import risa_pkg::*;
#(
  parameter int                  NUM_REGS   = 32,
  parameter int                  DATA_W     = 32,
  parameter int                  ADDR_W     = 32,
  parameter logic [255:0]        RO_MASK    = '0,
  parameter logic [255:0]        PULSE_MASK = 256'd1,
  parameter logic [DATA_W-1:0]   REG0_RESET = DATA_W'(32'hDEADBEEF)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             s_awaddr,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W/8-1:0]           s_wstrb,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [ADDR_W-1:0]             s_araddr,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [DATA_W-1:0]             s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [NUM_REGS*DATA_W-1:0]    reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]    status_i,
  output logic [NUM_REGS-1:0]           reg_wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDXL   = $clog2(STRB_W);
  localparam int IW     = $clog2(NUM_REGS);
  localparam logic [NUM_REGS-1:0] RO_VEC    = RO_MASK[NUM_REGS-1:0];
  localparam logic [NUM_REGS-1:0] PULSE_VEC = PULSE_MASK[NUM_REGS-1:0];

  // ---------------------------------------------------------------- write
  wr_state_t           wr_state_reg;
  wr_state_t           wr_state_next;
  logic                wr_accept;
  logic                wr_commit;
  logic                wr_joined;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic [IW-1:0]       wr_idx;
  logic                wr_oor;
  logic                wr_ro;
  logic                wr_en;
  logic [NUM_REGS-1:0] wr_hit;
  logic [1:0]          wr_resp;
  logic [1:0]          bresp_reg;

  assign wr_accept = (wr_state_reg == W_IDLE);

  axi_lite_wr_merge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_merge (
    .clk     (clk),
    .rst     (rst),
    .awaddr  (s_awaddr),
    .awvalid (s_awvalid),
    .awready (s_awready),
    .wdata   (s_wdata),
    .wstrb   (s_wstrb),
    .wvalid  (s_wvalid),
    .wready  (s_wready),
    .accept  (wr_accept),
    .consume (wr_commit),
    .joined  (wr_joined),
    .addr    (wr_addr),
    .data    (wr_data),
    .strb    (wr_strb)
  );

  assign wr_idx = wr_addr[IDXL +: IW];
  assign wr_oor = (32'(wr_idx) >= NUM_REGS);
  // A hit on an out-of-range index is impossible, so this is also 0 there.
  assign wr_ro  = |(wr_hit & RO_VEC);
  assign wr_en  = wr_commit && !wr_oor && !wr_ro;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_reg <= W_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_commit     = 1'b0;
    case (wr_state_reg)
      W_IDLE:   if (wr_joined) wr_state_next = W_COMMIT;
      W_COMMIT: begin
        wr_commit     = 1'b1;
        wr_state_next = W_RESP;
      end
      W_RESP:   if (s_bready) wr_state_next = W_IDLE;
      default:  wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bresp_reg <= RESP_OKAY;
    end else if (wr_commit) begin
      bresp_reg <= wr_resp;
    end
  end

  assign s_bvalid = (wr_state_reg == W_RESP);
  assign s_bresp  = bresp_reg;

  // ---------------------------------------------------------------- registers
  logic [DATA_W-1:0] rd_src [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;
      logic              pulse_reg;

      assign wr_hit[gi] = (wr_idx == IW'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_reg     <= (gi == 0) ? REG0_RESET : '0;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= wr_en && wr_hit[gi] && PULSE_VEC[gi];
          if (wr_en && wr_hit[gi]) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) q_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
            end
          end
        end
      end

      assign reg_q[gi*DATA_W +: DATA_W] = q_reg;
      assign reg_wr_pulse[gi]           = pulse_reg;
      assign rd_src[gi] = RO_VEC[gi] ? status_i[gi*DATA_W +: DATA_W] : q_reg;
    end
  endgenerate

  // ---------------------------------------------------------------- read
  rd_state_t         rd_state_reg;
  rd_state_t         rd_state_next;
  logic [IW-1:0]     rd_idx;
  logic              rd_oor;
  logic              ar_hs;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        rd_resp;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        rresp_reg;

  assign rd_idx    = s_araddr[IDXL +: IW];
  assign rd_oor    = (32'(rd_idx) >= NUM_REGS);
  assign rd_word   = rd_oor ? '0 : rd_src[rd_idx];
  assign s_arready = (rd_state_reg == R_IDLE);
  assign s_rvalid  = (rd_state_reg == R_DATA);
  assign ar_hs     = s_arvalid && s_arready;

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (s_arvalid) rd_state_next = R_DATA;
      R_DATA:  if (s_rready) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Captured on the same edge a write commits, so a colliding read sees the
  // pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      if (ar_hs) begin
        rdata_reg <= rd_word;
        rresp_reg <= rd_resp;
      end
    end
  end

  assign s_rdata = rdata_reg;
  assign s_rresp = rresp_reg;

  // ---------------------------------------------------------------- responses
`ifdef AXI_LITE_REG_DECERR_EN
  assign wr_resp = wr_oor ? RESP_DECERR : (wr_ro ? RESP_SLVERR : RESP_OKAY);
  assign rd_resp = rd_oor ? RESP_DECERR : RESP_OKAY;
`else
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  // Address bits outside the word index and status words of RW registers are
  // intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{wr_addr, s_araddr, status_i};

endmodule
